// File: rtl/sram_word_engine.sv
// Word-wide access engine for a 16-bit async SRAM: splits a DATA_W word into
// BEATS 16-bit beats behind a valid/ready request and a held response channel.
module sram_word_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 20,
    parameter int WAIT_CYC   = 2,
    parameter int WORD_ORDER = 0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_bmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [15:0]         sram_dq,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic                sram_ce_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam int BEATS  = DATA_W / 16;
    localparam int MASK_W = DATA_W / 8;
    localparam int EXT_W  = ADDR_W + 5;
    localparam logic [EXT_W-1:0] ADDR_MAX = {{(EXT_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SETUP, S_STROBE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   bmask_q, bmask_d;
    logic [4:0]          beat_q, beat_d;
    logic [3:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;

    logic [EXT_W-1:0]    last_ext;
    logic [ADDR_W-1:0]   base_addr;
    logic [1:0]          lane_en;
    int                  cur_slice, nxt_slice;

    function automatic int slice_of(input logic [4:0] b);
        if (WORD_ORDER != 0) slice_of = BEATS - 1 - int'(b);
        else                 slice_of = int'(b);
    endfunction

    // Range check is done wide so an overflowing word is caught before any beat address wraps.
    assign last_ext  = EXT_W'(addr_q) * EXT_W'(BEATS) + EXT_W'(BEATS - 1);
    assign base_addr = addr_q * ADDR_W'(BEATS);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cur_slice = slice_of(beat_q);

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    bmask_d = req_bmask;
                    beat_d  = '0;
                    wait_d  = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (last_ext > ADDR_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_d  = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (wait_q == 4'(WAIT_CYC - 1)) begin
                    if (!we_q) rdata_d[16*cur_slice +: 16] = sram_dq;
                    if (beat_q == 5'(BEATS - 1)) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d  = beat_q + 5'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are derived from the state being entered so every output is a flop.
        nxt_slice   = slice_of(beat_d);
        lane_en     = bmask_d[2*nxt_slice +: 2];
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        sram_addr_d = sram_addr_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        if (state_d == S_SETUP || state_d == S_STROBE) begin
            sram_addr_d = base_addr + ADDR_W'(beat_d);
            ce_n_d      = 1'b0;
            if (we_q) begin
                ub_n_d = !lane_en[1];
                lb_n_d = !lane_en[0];
                if (state_d == S_STROBE) begin
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_q[16*nxt_slice +: 16];
                    we_n_d   = !(|lane_en);
                end
            end else begin
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bmask_q     <= bmask_d;
            beat_q      <= beat_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            sram_addr_q <= sram_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_word_engine.sv
// Directed bench for sram_word_engine: three instances (default, WORD_ORDER=1, DATA_W=64),
// each wired to a behavioural async SRAM that commits a write after a full-width we_n pulse.
module tb_sram_word_engine;

    logic        CLOCK_50;
    logic        reset;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [19:0] req_addr  [3];
    logic [63:0] wdata     [3];
    logic [7:0]  bmask     [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_err   [3];
    logic        busy      [3];
    logic [19:0] sram_addr [3];
    logic        we_n [3], oe_n [3], ce_n [3], ub_n [3], lb_n [3];
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    wire  [15:0] dq0, dq1, dq2;

    logic [15:0] mem [logic [21:0]];
    logic        rd_en  [3];
    logic [15:0] rd_val [3];
    int          wp_cnt [3];
    int          ce_cyc [3], we_cyc [3], we_lb [3], we_ub [3];
    logic [19:0] we_addr [3];

    int n_checks = 0;
    int n_errors = 0;

    sram_word_engine #(.DATA_W(32), .ADDR_W(20), .WAIT_CYC(2), .WORD_ORDER(0)) u0 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(wdata[0][31:0]), .req_bmask(bmask[0][3:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rd0), .rsp_err(rsp_err[0]),
        .busy(busy[0]), .sram_addr(sram_addr[0]), .sram_dq(dq0),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]),
        .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]));

    sram_word_engine #(.DATA_W(32), .ADDR_W(20), .WAIT_CYC(2), .WORD_ORDER(1)) u1 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(wdata[1][31:0]), .req_bmask(bmask[1][3:0]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rd1), .rsp_err(rsp_err[1]),
        .busy(busy[1]), .sram_addr(sram_addr[1]), .sram_dq(dq1),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]),
        .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]));

    sram_word_engine #(.DATA_W(64), .ADDR_W(20), .WAIT_CYC(2), .WORD_ORDER(0)) u2 (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(wdata[2]), .req_bmask(bmask[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rd2), .rsp_err(rsp_err[2]),
        .busy(busy[2]), .sram_addr(sram_addr[2]), .sram_dq(dq2),
        .sram_we_n(we_n[2]), .sram_oe_n(oe_n[2]), .sram_ce_n(ce_n[2]),
        .sram_ub_n(ub_n[2]), .sram_lb_n(lb_n[2]));

    assign dq0 = rd_en[0] ? rd_val[0] : 16'hzzzz;
    assign dq1 = rd_en[1] ? rd_val[1] : 16'hzzzz;
    assign dq2 = rd_en[2] ? rd_val[2] : 16'hzzzz;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [15:0] memrd(input int i, input logic [19:0] a);
        logic [21:0] k;
        k = {i[1:0], a};
        if (mem.exists(k)) return mem[k];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] dq_of(input int i);
        case (i)
            0:       return dq0;
            1:       return dq1;
            default: return dq2;
        endcase
    endfunction

    function automatic logic [63:0] rdata_of(input int i);
        case (i)
            0:       return {32'h0, rd0};
            1:       return {32'h0, rd1};
            default: return rd2;
        endcase
    endfunction

    // SRAM model: reads drive dq from the negedge after oe_n falls; a write needs two
    // consecutive strobe cycles at one address before it lands, so an aborted pulse is lost.
    always @(negedge CLOCK_50) begin
        logic [15:0] cur;
        for (int i = 0; i < 3; i++) begin
            rd_en[i]  <= !ce_n[i] && !oe_n[i] && we_n[i];
            rd_val[i] <= memrd(i, sram_addr[i]);
            if (!ce_n[i]) ce_cyc[i]++;
            if (!ce_n[i] && !we_n[i]) begin
                we_cyc[i]++;
                if (!lb_n[i]) we_lb[i]++;
                if (!ub_n[i]) we_ub[i]++;
                we_addr[i] = sram_addr[i];
                wp_cnt[i]++;
                if (wp_cnt[i] == 2) begin
                    cur = memrd(i, sram_addr[i]);
                    if (!lb_n[i]) cur[7:0]  = dq_of(i)[7:0];
                    if (!ub_n[i]) cur[15:8] = dq_of(i)[15:8];
                    mem[{i[1:0], sram_addr[i]}] = cur;
                end
            end else begin
                wp_cnt[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_counts(input int i);
        ce_cyc[i] = 0;
        we_cyc[i] = 0;
        we_lb[i]  = 0;
        we_ub[i]  = 0;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic start_req(input int i, input logic we, input logic [19:0] a,
                             input logic [63:0] wd, input logic [7:0] bm);
        int n;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 50) chk("ready_wait", 64'(n), 64'(0));
        req_we[i]    = we;
        req_addr[i]  = a;
        wdata[i]     = wd;
        bmask[i]     = bm;
        req_valid[i] = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int lat);
        lat = 1;
        while (rsp_valid[i] !== 1'b1 && lat < 200) begin
            @(negedge CLOCK_50);
            lat++;
        end
    endtask

    task automatic ack(input int i);
        rsp_ready[i] = 1'b1;
        @(negedge CLOCK_50);
        rsp_ready[i] = 1'b0;
    endtask

    task automatic xfer(input int i, input logic we, input logic [19:0] a, input logic [63:0] wd,
                        input logic [7:0] bm, output logic [63:0] rd, output logic err, output int lat);
        start_req(i, we, a, wd, bm);
        wait_rsp(i, lat);
        rd  = rdata_of(i);
        err = rsp_err[i];
        ack(i);
    endtask

    initial begin
        logic [63:0] rd;
        logic        err;
        int          lat;

        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        err;
        int          lat;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            wdata[i] = '0; bmask[i] = '0; rsp_ready[i] = 1'b0;
            rd_en[i] = 1'b0; rd_val[i] = '0; wp_cnt[i] = 0; we_addr[i] = '0;
            clr_counts(i);
        end
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'(1));
            chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'(0));
            chk("rst_busy",      64'(busy[i]),      64'(0));
            chk("rst_rsp_err",   64'(rsp_err[i]),   64'(0));
            chk("rst_rdata",     rdata_of(i),       64'(0));
            chk("rst_sram_addr", 64'(sram_addr[i]), 64'(0));
            chk("rst_pins_n", 64'({ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]}), 64'(5'b11111));
        end
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Write then read, default beat order
        xfer(0, 1'b1, 20'd5, 64'hDEAD_BEEF, 8'hF, rd, err, lat);
        chk("wr_latency", 64'(lat), 64'(8));
        chk("wr_err", 64'(err), 64'(0));
        chk("wr_rdata_zero", rd, 64'(0));
        chk("wr_loc10", 64'(memrd(0, 20'd10)), 64'(16'hBEEF));
        chk("wr_loc11", 64'(memrd(0, 20'd11)), 64'(16'hDEAD));
        xfer(0, 1'b0, 20'd5, 64'h0, 8'h0, rd, err, lat);
        chk("rd_latency", 64'(lat), 64'(8));
        chk("rd_data", rd, 64'hDEAD_BEEF);
        chk("rd_err", 64'(err), 64'(0));

        // Reversed beat order
        xfer(1, 1'b1, 20'd5, 64'hDEAD_BEEF, 8'hF, rd, err, lat);
        chk("wo1_loc10", 64'(memrd(1, 20'd10)), 64'(16'hDEAD));
        chk("wo1_loc11", 64'(memrd(1, 20'd11)), 64'(16'hBEEF));
        xfer(1, 1'b0, 20'd5, 64'h0, 8'h0, rd, err, lat);
        chk("wo1_rd_data", rd, 64'hDEAD_BEEF);

        // Partial byte write: only byte 1 (beat 0 upper lane)
        clr_counts(0);
        xfer(0, 1'b1, 20'd5, 64'h1234_5678, 8'b0010, rd, err, lat);
        chk("bm_we_cycles", 64'(we_cyc[0]), 64'(2));
        chk("bm_ub_cycles", 64'(we_ub[0]), 64'(2));
        chk("bm_lb_cycles", 64'(we_lb[0]), 64'(0));
        chk("bm_we_addr", 64'(we_addr[0]), 64'(10));
        xfer(0, 1'b0, 20'd5, 64'h0, 8'h0, rd, err, lat);
        chk("bm_rd_data", rd, 64'hDEAD_56EF);

        // 64-bit: top-of-range word accepted, next word rejected
        xfer(2, 1'b1, 20'h3FFFF, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, err, lat);
        chk("w64_err", 64'(err), 64'(0));
        chk("w64_latency", 64'(lat), 64'(14));
        chk("w64_locFFFFC", 64'(memrd(2, 20'hFFFFC)), 64'(16'hCDEF));
        chk("w64_locFFFFF", 64'(memrd(2, 20'hFFFFF)), 64'(16'h0123));
        xfer(2, 1'b0, 20'h3FFFF, 64'h0, 8'h0, rd, err, lat);
        chk("w64_rd_data", rd, 64'h0123_4567_89AB_CDEF);
        clr_counts(2);
        xfer(2, 1'b0, 20'h40000, 64'h0, 8'h0, rd, err, lat);
        chk("ovf_err", 64'(err), 64'(1));
        chk("ovf_latency", 64'(lat), 64'(2));
        chk("ovf_rdata", rd, 64'(0));
        chk("ovf_ce_cycles", 64'(ce_cyc[2]), 64'(0));
        chk("ovf_sram_addr", 64'(sram_addr[2]), 64'(20'hFFFFF));

        // Response held under back-pressure; a pending request waits for IDLE
        start_req(0, 1'b0, 20'd5, 64'h0, 8'h0);
        wait_rsp(0, lat);
        chk("bp_latency", 64'(lat), 64'(8));
        req_we[0] = 1'b0; req_addr[0] = 20'd5; req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLOCK_50);
            chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'(1));
            chk("bp_rdata", rdata_of(0), 64'hDEAD_56EF);
            chk("bp_req_ready", 64'(req_ready[0]), 64'(0));
        end
        rsp_ready[0] = 1'b1;
        @(negedge CLOCK_50);
        rsp_ready[0] = 1'b0;
        chk("bp_after_ack_valid", 64'(rsp_valid[0]), 64'(0));
        chk("bp_after_ack_ready", 64'(req_ready[0]), 64'(1));
        chk("bp_after_ack_busy",  64'(busy[0]),      64'(0));
        @(negedge CLOCK_50);
        req_valid[0] = 1'b0;
        chk("bp_accept_busy",  64'(busy[0]),      64'(1));
        chk("bp_accept_ready", 64'(req_ready[0]), 64'(0));
        wait_rsp(0, lat);
        chk("bp_second_rdata", rdata_of(0), 64'hDEAD_56EF);
        ack(0);

        // Reset during beat 1 strobe of a write
        start_req(0, 1'b1, 20'd7, 64'hCAFE_1234, 8'hF);
        for (int c = 2; c <= 6; c++) @(negedge CLOCK_50);
        chk("abort_pre_we_n", 64'(we_n[0]), 64'(0));
        chk("abort_pre_addr", 64'(sram_addr[0]), 64'(15));
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_pins_n", 64'({ce_n[0], oe_n[0], we_n[0]}), 64'(3'b111));
        chk("abort_dq_released", 64'(u0.dq_oe_q), 64'(0));
        chk("abort_req_ready", 64'(req_ready[0]), 64'(1));
        chk("abort_rsp_valid", 64'(rsp_valid[0]), 64'(0));
        chk("abort_busy", 64'(busy[0]), 64'(0));
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("abort_no_rsp", 64'(rsp_valid[0]), 64'(0));
        xfer(0, 1'b0, 20'd7, 64'h0, 8'h0, rd, err, lat);
        chk("abort_rd_data", rd, 64'h0000_1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
